// File: rtl/axi2sdram_pkg.sv
// Shared types for the AXI-Lite to SDRAM request path.
// Scheduler state encoding and the read-timeout filler word.
package axi2sdram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RD,
        PUSH_RD
    } sched_state_e;

    localparam logic [31:0] RD_FILLER = 32'hDEAD_BEEF;

endpackage

// File: rtl/sdram_req_scheduler_rd_timeout_counter.sv
// Read-wait cycle counter for the SDRAM request scheduler.
// Saturates at MAX_COUNT; tc stays high until the next clear.
module rd_timeout_counter #(
    parameter int MAX_COUNT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = (MAX_COUNT < 2) ? 1 : $clog2(MAX_COUNT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tc = (cnt_q == CW'(MAX_COUNT));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !tc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sdram_req_scheduler.sv
// Pops AXI-Lite transactions from the RW/address/data FIFOs in order and
// issues them one at a time to the SDRAM controller, returning read data.
module sdram_req_scheduler
    import axi2sdram_pkg::*;
#(
    parameter int ADDR_WIDTH       = 32,
    parameter int DATA_WIDTH       = 32,
    parameter int SDRAM_ADDR_WIDTH = 24,
    parameter int RD_TIMEOUT       = 255
) (
    input  logic                        s_axil_clk,
    input  logic                        s_axil_resetn,
    input  logic                        rw_fifo_dout,
    input  logic                        rw_fifo_empty,
    output logic                        rw_fifo_rd_en,
    input  logic [ADDR_WIDTH-1:0]       waddr_fifo_dout,
    input  logic                        waddr_fifo_empty,
    output logic                        waddr_fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]       wdata_fifo_dout,
    input  logic                        wdata_fifo_empty,
    output logic                        wdata_fifo_rd_en,
    input  logic [ADDR_WIDTH-1:0]       raddr_fifo_dout,
    input  logic                        raddr_fifo_empty,
    output logic                        raddr_fifo_rd_en,
    output logic [DATA_WIDTH-1:0]       rdata_fifo_din,
    output logic                        rdata_fifo_wr_en,
    input  logic                        rdata_fifo_full,
    output logic                        ctrl_req_valid,
    input  logic                        ctrl_req_ready,
    output logic                        ctrl_req_wr,
    output logic [SDRAM_ADDR_WIDTH-1:0] ctrl_req_addr,
    output logic [DATA_WIDTH-1:0]       ctrl_req_wdata,
    input  logic                        ctrl_rd_valid,
    input  logic [DATA_WIDTH-1:0]       ctrl_rd_data,
    output logic                        busy,
    output logic                        rd_timeout_err
);

    localparam logic [DATA_WIDTH-1:0] FILL = DATA_WIDTH'(RD_FILLER);

    sched_state_e state_q, state_d;

    logic                        req_valid_q, req_valid_d;
    logic                        req_wr_q, req_wr_d;
    logic [SDRAM_ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [DATA_WIDTH-1:0]       req_wdata_q, req_wdata_d;
    logic [DATA_WIDTH-1:0]       rdata_q, rdata_d;
    logic                        tmo_err_q, tmo_err_d;
    logic                        busy_q, busy_d;
    logic                        rw_pop_q, rw_pop_d;
    logic                        waddr_pop_q, waddr_pop_d;
    logic                        wdata_pop_q, wdata_pop_d;
    logic                        raddr_pop_q, raddr_pop_d;

    logic cnt_clr;
    logic cnt_en;
    logic cnt_tc;

    // Only the word-address slice is forwarded; byte-lane and high bits drop.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{waddr_fifo_dout, raddr_fifo_dout};

    rd_timeout_counter #(
        .MAX_COUNT (RD_TIMEOUT)
    ) u_rd_timeout_counter (
        .clk   (s_axil_clk),
        .rst_n (s_axil_resetn),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .tc    (cnt_tc)
    );

    always_comb begin
        state_d     = state_q;
        req_valid_d = req_valid_q;
        req_wr_d    = req_wr_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        rdata_d     = rdata_q;
        tmo_err_d   = tmo_err_q;
        rw_pop_d    = 1'b0;
        waddr_pop_d = 1'b0;
        wdata_pop_d = 1'b0;
        raddr_pop_d = 1'b0;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!rw_fifo_empty) begin
                    if (rw_fifo_dout) begin
                        if (!waddr_fifo_empty && !wdata_fifo_empty) begin
                            rw_pop_d    = 1'b1;
                            waddr_pop_d = 1'b1;
                            wdata_pop_d = 1'b1;
                            req_addr_d  = waddr_fifo_dout[SDRAM_ADDR_WIDTH+1:2];
                            req_wdata_d = wdata_fifo_dout;
                            req_wr_d    = 1'b1;
                            req_valid_d = 1'b1;
                            state_d     = ISSUE;
                        end
                    end else if (!raddr_fifo_empty) begin
                        rw_pop_d    = 1'b1;
                        raddr_pop_d = 1'b1;
                        req_addr_d  = raddr_fifo_dout[SDRAM_ADDR_WIDTH+1:2];
                        req_wr_d    = 1'b0;
                        req_valid_d = 1'b1;
                        state_d     = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (ctrl_req_ready) begin
                    req_valid_d = 1'b0;
                    cnt_clr     = 1'b1;
                    state_d     = req_wr_q ? IDLE : WAIT_RD;
                end
            end
            WAIT_RD: begin
                cnt_en = 1'b1;
                if (ctrl_rd_valid) begin
                    rdata_d = ctrl_rd_data;
                    state_d = PUSH_RD;
                end else if (cnt_tc) begin
                    // Complete the AXI read with a marker word rather than hang.
                    rdata_d   = FILL;
                    tmo_err_d = 1'b1;
                    state_d   = PUSH_RD;
                end
            end
            PUSH_RD: begin
                if (!rdata_fifo_full) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge s_axil_clk or negedge s_axil_resetn) begin
        if (!s_axil_resetn) begin
            state_q     <= IDLE;
            req_valid_q <= 1'b0;
            req_wr_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            rdata_q     <= '0;
            tmo_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            rw_pop_q    <= 1'b0;
            waddr_pop_q <= 1'b0;
            wdata_pop_q <= 1'b0;
            raddr_pop_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_valid_q <= req_valid_d;
            req_wr_q    <= req_wr_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            rdata_q     <= rdata_d;
            tmo_err_q   <= tmo_err_d;
            busy_q      <= busy_d;
            rw_pop_q    <= rw_pop_d;
            waddr_pop_q <= waddr_pop_d;
            wdata_pop_q <= wdata_pop_d;
            raddr_pop_q <= raddr_pop_d;
        end
    end

    // Push is combinational on full so a held word lands the cycle full drops.
    assign rdata_fifo_wr_en = (state_q == PUSH_RD) && !rdata_fifo_full;
    assign rdata_fifo_din   = rdata_q;
    assign rw_fifo_rd_en    = rw_pop_q;
    assign waddr_fifo_rd_en = waddr_pop_q;
    assign wdata_fifo_rd_en = wdata_pop_q;
    assign raddr_fifo_rd_en = raddr_pop_q;
    assign ctrl_req_valid   = req_valid_q;
    assign ctrl_req_wr      = req_wr_q;
    assign ctrl_req_addr    = req_addr_q;
    assign ctrl_req_wdata   = req_wdata_q;
    assign busy             = busy_q;
    assign rd_timeout_err   = tmo_err_q;

endmodule

// File: tb/tb_sdram_req_scheduler.sv
// Scoreboard bench for sdram_req_scheduler: FIFO, controller and
// read-data sink models around the DUT, with a transaction-level reference.
module tb_sdram_req_scheduler;

    localparam int TMO = 20;

    logic        clk;
    logic        rst_n;
    logic        rw_fifo_dout, rw_fifo_empty, rw_fifo_rd_en;
    logic [31:0] waddr_fifo_dout;
    logic        waddr_fifo_empty, waddr_fifo_rd_en;
    logic [31:0] wdata_fifo_dout;
    logic        wdata_fifo_empty, wdata_fifo_rd_en;
    logic [31:0] raddr_fifo_dout;
    logic        raddr_fifo_empty, raddr_fifo_rd_en;
    logic [31:0] rdata_fifo_din;
    logic        rdata_fifo_wr_en, rdata_fifo_full;
    logic        ctrl_req_valid, ctrl_req_ready, ctrl_req_wr;
    logic [23:0] ctrl_req_addr;
    logic [31:0] ctrl_req_wdata;
    logic        ctrl_rd_valid;
    logic [31:0] ctrl_rd_data;
    logic        busy, rd_timeout_err;

    sdram_req_scheduler #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .SDRAM_ADDR_WIDTH(24), .RD_TIMEOUT(TMO)
    ) dut (
        .s_axil_clk(clk), .s_axil_resetn(rst_n),
        .rw_fifo_dout(rw_fifo_dout), .rw_fifo_empty(rw_fifo_empty),
        .rw_fifo_rd_en(rw_fifo_rd_en),
        .waddr_fifo_dout(waddr_fifo_dout), .waddr_fifo_empty(waddr_fifo_empty),
        .waddr_fifo_rd_en(waddr_fifo_rd_en),
        .wdata_fifo_dout(wdata_fifo_dout), .wdata_fifo_empty(wdata_fifo_empty),
        .wdata_fifo_rd_en(wdata_fifo_rd_en),
        .raddr_fifo_dout(raddr_fifo_dout), .raddr_fifo_empty(raddr_fifo_empty),
        .raddr_fifo_rd_en(raddr_fifo_rd_en),
        .rdata_fifo_din(rdata_fifo_din), .rdata_fifo_wr_en(rdata_fifo_wr_en),
        .rdata_fifo_full(rdata_fifo_full),
        .ctrl_req_valid(ctrl_req_valid), .ctrl_req_ready(ctrl_req_ready),
        .ctrl_req_wr(ctrl_req_wr), .ctrl_req_addr(ctrl_req_addr),
        .ctrl_req_wdata(ctrl_req_wdata),
        .ctrl_rd_valid(ctrl_rd_valid), .ctrl_rd_data(ctrl_rd_data),
        .busy(busy), .rd_timeout_err(rd_timeout_err)
    );

    typedef struct {bit wr; logic [23:0] addr; logic [31:0] wdata;} req_t;
    typedef struct {int delay; bit tmo; logic [31:0] data;} plan_t;
    typedef struct {logic [31:0] data; bit err;} rexp_t;

    req_t        exp_req_q[$];
    plan_t       plan_q[$];
    rexp_t       exp_rd_q[$];
    bit          q_rw[$];
    logic [31:0] q_waddr[$], q_wdata[$], q_raddr[$];

    int n_cmp = 0;
    int n_bad = 0;
    bit tmo_seen = 1'b0;
    int ready_mode = 0;
    bit rnd_full = 1'b0;
    bit force_full = 1'b0;
    bit spur_en = 1'b1;

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: word address is the byte address divided by 4, modulo 2^24.
    function automatic logic [23:0] word_addr(logic [31:0] a);
        return 24'((a / 4) % 32'h0100_0000);
    endfunction

    task automatic add_txn(bit wr, logic [31:0] a, logic [31:0] d,
                           int delay, bit tmo, bit drop, bit hold_wdata);
        req_t r;
        plan_t p;
        rexp_t e;
        q_rw.push_back(wr);
        r.wr = wr;
        r.addr = word_addr(a);
        r.wdata = wr ? d : 32'h0;
        exp_req_q.push_back(r);
        if (wr) begin
            q_waddr.push_back(a);
            if (!hold_wdata) q_wdata.push_back(d);
        end else begin
            q_raddr.push_back(a);
            p.delay = delay;
            p.tmo = tmo;
            p.data = d;
            plan_q.push_back(p);
            if (!drop) begin
                tmo_seen = tmo_seen | tmo;
                e.data = tmo ? 32'hDEAD_BEEF : d;
                e.err = tmo_seen;
                exp_rd_q.push_back(e);
            end
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // FIFO models: first-word-fall-through, popped at the edge rd_en was seen.
    initial begin
        bit p_rw, p_wa, p_wd, p_ra;
        rw_fifo_dout = 0; rw_fifo_empty = 1;
        waddr_fifo_dout = 0; waddr_fifo_empty = 1;
        wdata_fifo_dout = 0; wdata_fifo_empty = 1;
        raddr_fifo_dout = 0; raddr_fifo_empty = 1;
        forever begin
            @(negedge clk);
            p_rw = rw_fifo_rd_en; p_wa = waddr_fifo_rd_en;
            p_wd = wdata_fifo_rd_en; p_ra = raddr_fifo_rd_en;
            @(posedge clk);
            #1;
            if (p_rw) begin
                check("rw_pop_nonempty", 128'(q_rw.size() != 0), 128'(1));
                if (q_rw.size() != 0) begin
                    check("pop_set", 128'({p_wa, p_wd, p_ra}),
                          128'(q_rw[0] ? 3'b110 : 3'b001));
                    void'(q_rw.pop_front());
                end
            end else if (p_wa || p_wd || p_ra) begin
                check("stray_pop", 128'({p_wa, p_wd, p_ra}), 128'(0));
            end
            if (p_wa) begin
                check("waddr_pop_nonempty", 128'(q_waddr.size() != 0), 128'(1));
                if (q_waddr.size() != 0) void'(q_waddr.pop_front());
            end
            if (p_wd) begin
                check("wdata_pop_nonempty", 128'(q_wdata.size() != 0), 128'(1));
                if (q_wdata.size() != 0) void'(q_wdata.pop_front());
            end
            if (p_ra) begin
                check("raddr_pop_nonempty", 128'(q_raddr.size() != 0), 128'(1));
                if (q_raddr.size() != 0) void'(q_raddr.pop_front());
            end
            rw_fifo_empty = (q_rw.size() == 0);
            rw_fifo_dout = rw_fifo_empty ? 1'b0 : q_rw[0];
            waddr_fifo_empty = (q_waddr.size() == 0);
            waddr_fifo_dout = waddr_fifo_empty ? 32'h0 : q_waddr[0];
            wdata_fifo_empty = (q_wdata.size() == 0);
            wdata_fifo_dout = wdata_fifo_empty ? 32'h0 : q_wdata[0];
            raddr_fifo_empty = (q_raddr.size() == 0);
            raddr_fifo_dout = raddr_fifo_empty ? 32'h0 : q_raddr[0];
        end
    end

    // SDRAM controller model: ready policy, delayed read responses, stray pulses.
    initial begin
        bit hs, hs_wr;
        int cd;
        plan_t cur;
        cd = -1;
        cur.data = 0; cur.delay = 0; cur.tmo = 0;
        ctrl_req_ready = 0; ctrl_rd_valid = 0; ctrl_rd_data = 0;
        forever begin
            @(negedge clk);
            hs = rst_n && ctrl_req_valid && ctrl_req_ready;
            hs_wr = ctrl_req_wr;
            @(posedge clk);
            #1;
            ctrl_rd_valid = 1'b0;
            if (hs && !hs_wr && plan_q.size() != 0) begin
                cur = plan_q.pop_front();
                cd = cur.tmo ? -1 : cur.delay;
            end
            if (cd == 0) begin
                ctrl_rd_valid = 1'b1;
                ctrl_rd_data = cur.data;
                cd = -1;
            end else if (cd > 0) begin
                cd--;
            end else if (spur_en && !busy && $urandom_range(0, 7) == 0) begin
                ctrl_rd_valid = 1'b1;
                ctrl_rd_data = $urandom;
            end
            case (ready_mode)
                0: ctrl_req_ready = 1'b1;
                1: ctrl_req_ready = 1'($urandom_range(0, 1));
                default: ctrl_req_ready = 1'b0;
            endcase
        end
    end

    initial begin
        rdata_fifo_full = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rdata_fifo_full = force_full ||
                              (rnd_full && $urandom_range(0, 3) == 0);
        end
    end

    // Request monitor.
    initial begin
        req_t e;
        bit prev_stall, prev_hs;
        logic [56:0] prev_v;
        prev_stall = 0; prev_hs = 0; prev_v = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (prev_stall)
                    check("req_stable", 128'({ctrl_req_valid, ctrl_req_wr,
                          ctrl_req_addr, ctrl_req_wdata}), 128'({1'b1, prev_v}));
                if (prev_hs)
                    check("valid_drop", 128'(ctrl_req_valid), 128'(0));
                if (ctrl_req_valid && ctrl_req_ready) begin
                    if (exp_req_q.size() == 0) begin
                        check("req_unexpected", 128'(1), 128'(0));
                    end else begin
                        e = exp_req_q.pop_front();
                        check("req_wr", 128'(ctrl_req_wr), 128'(e.wr));
                        check("req_addr", 128'(ctrl_req_addr), 128'(e.addr));
                        if (e.wr)
                            check("req_wdata", 128'(ctrl_req_wdata), 128'(e.wdata));
                    end
                end
            end
            prev_stall = rst_n && ctrl_req_valid && !ctrl_req_ready;
            prev_hs = rst_n && ctrl_req_valid && ctrl_req_ready;
            prev_v = {ctrl_req_wr, ctrl_req_addr, ctrl_req_wdata};
        end
    end

    // Read-data sink monitor.
    initial begin
        rexp_t e;
        forever begin
            @(negedge clk);
            if (rdata_fifo_wr_en) begin
                check("push_while_full", 128'(rdata_fifo_full), 128'(0));
                if (exp_rd_q.size() == 0) begin
                    check("rd_unexpected", 128'(1), 128'(0));
                end else begin
                    e = exp_rd_q.pop_front();
                    check("rd_data", 128'(rdata_fifo_din), 128'(e.data));
                    check("rd_err", 128'(rd_timeout_err), 128'(e.err));
                end
            end
        end
    end

    task automatic drain(int budget);
        int n;
        n = 0;
        while ((exp_req_q.size() != 0 || exp_rd_q.size() != 0 || busy ||
                q_rw.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check("drain_timeout", 128'(1), 128'(0));
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [96:0] out_vec();
        return {rw_fifo_rd_en, waddr_fifo_rd_en, wdata_fifo_rd_en,
                raddr_fifo_rd_en, rdata_fifo_wr_en, ctrl_req_valid,
                ctrl_req_wr, busy, rd_timeout_err, ctrl_req_addr,
                ctrl_req_wdata, rdata_fifo_din};
    endfunction

    initial begin
        int n;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2 check("reset_state", 128'(out_vec()), 128'(0));
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        spur_en = 1'b1;

        // Single write: latency and one-cycle pulses.
        @(posedge clk);
        add_txn(1, 32'h0000_0010, 32'hA5A5_5A5A, 0, 0, 0, 0);
        @(negedge clk) check("wr_lat_c0", 128'(ctrl_req_valid), 128'(0));
        @(negedge clk) check("wr_lat_c1", 128'({ctrl_req_valid, rw_fifo_rd_en}), 128'(2'b11));
        check("wr_addr_direct", 128'(ctrl_req_addr), 128'(24'h000004));
        @(negedge clk) check("wr_lat_c2", 128'({ctrl_req_valid, rw_fifo_rd_en}), 128'(0));
        drain(50);

        add_txn(0, 32'h0000_0100, 32'h1234_5678, 5, 0, 0, 0);
        drain(50);

        // Controller backpressure for ten cycles.
        ready_mode = 2;
        add_txn(1, 32'h00AB_CDE4, 32'h0F0F_F0F0, 0, 0, 0, 0);
        repeat (10) @(negedge clk);
        ready_mode = 0;
        drain(50);

        // Read data sink full when the response returns.
        force_full = 1'b1;
        add_txn(0, 32'h0000_0200, 32'h7777_1111, 3, 0, 0, 0);
        n = 0;
        while (!ctrl_rd_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("rd_valid_wait", 128'(1), 128'(0));
        repeat (4) @(posedge clk);
        force_full = 1'b0;
        drain(50);

        add_txn(0, 32'h0000_0300, 32'h0, 0, 1, 0, 0);
        drain(TMO + 40);
        check("err_sticky", 128'(rd_timeout_err), 128'(1));

        // Write stalls while its data word is absent.
        add_txn(1, 32'h0000_0400, 32'h5555_AAAA, 0, 0, 0, 1);
        repeat (6) @(negedge clk);
        check("wdata_wait_busy", 128'(busy), 128'(0));
        check("wdata_wait_nopop", 128'(q_rw.size()), 128'(1));
        q_wdata.push_back(32'h5555_AAAA);
        drain(50);

        // Randomized traffic.
        ready_mode = 1;
        rnd_full = 1'b1;
        for (int i = 0; i < 150; i++) begin
            add_txn(1'($urandom_range(0, 1)), $urandom, $urandom,
                    $urandom_range(0, 12), ($urandom_range(0, 9) == 0), 0, 0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        drain(20000);
        check("err_end", 128'(rd_timeout_err), 128'(tmo_seen));

        // Reset while a read is waiting for data.
        ready_mode = 0;
        rnd_full = 1'b0;
        add_txn(0, 32'h0000_0500, 32'hCAFE_F00D, 8, 0, 1, 0);
        n = 0;
        while (exp_req_q.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30) check("reset_hs_wait", 128'(1), 128'(0));
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check("reset_mid_outputs", 128'(out_vec()), 128'(0));
        tmo_seen = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("post_reset_idle", 128'({busy, rd_timeout_err}), 128'(0));
        end
        add_txn(0, 32'h0000_0600, 32'h3C3C_C3C3, 2, 0, 0, 0);
        drain(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
